multi_channel_scoreboard: RTL and testbench

MULTI_CHANNEL_SCOREBOARD -- requirements
Module: multi_channel_scoreboard

---
 rtl/multi_channel_scoreboard_if.sv | 30 +++
 rtl/multi_channel_scoreboard.sv | 147 ++++++++++++++
 tb/tb_multi_channel_scoreboard.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_scoreboard_if.sv
// Bundle of FIFO-monitor strobes/data and scoreboard status for multi_channel_scoreboard.
interface multi_channel_scoreboard_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int CHW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic                    start;
  logic [CHW-1:0]          sel;
  logic [NUM_CH*WIDTH-1:0] flat_data_in;
  logic [NUM_CH*WIDTH-1:0] flat_data_out;
  logic                    armed;
  logic                    data_out_vld;
  logic                    prop_signal;
  logic                    done;
  logic [1:0]              err;
  logic [CHW-1:0]          err_ch;

  modport master (
    output push, pop, start, sel, flat_data_in, flat_data_out,
    input  armed, data_out_vld, prop_signal, done, err, err_ch
  );

  modport slave (
    input  push, pop, start, sel, flat_data_in, flat_data_out,
    output armed, data_out_vld, prop_signal, done, err, err_ch
  );
endinterface

// File: rtl/multi_channel_scoreboard.sv
// Tracks occupancy of NUM_CH FIFOs, captures one "magic" packet on request and
// checks that it leaves its FIFO unchanged; flags data mismatches and protocol abuse.
module multi_channel_scoreboard #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int REARM  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_channel_scoreboard_if.slave bus
);
  localparam int CNTWID = $clog2(DEPTH) + 1;
  localparam int CHW    = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNTWID-1:0] occ_q [NUM_CH];
  logic [CNTWID-1:0] occ_d [NUM_CH];
  logic [CNTWID-1:0] pos_q, pos_d;
  logic [WIDTH-1:0]  magic_q, magic_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [1:0]        err_q, err_d;
  logic [CHW-1:0]    err_ch_q, err_ch_d;

  logic [NUM_CH-1:0] push_acc, pop_acc, proto_err;
  logic              sel_ok, sel_push_acc, sel_pop_acc;
  logic [CNTWID-1:0] sel_occ;
  logic [WIDTH-1:0]  sel_data, ch_data;
  logic              ch_pop_acc, vld, mismatch, found;

  always_comb begin
    sel_ok       = 1'b0;
    sel_push_acc = 1'b0;
    sel_pop_acc  = 1'b0;
    sel_occ      = '0;
    sel_data     = '0;
    ch_pop_acc   = 1'b0;
    ch_data      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      push_acc[c]  = bus.push[c] && (occ_q[c] < CNTWID'(DEPTH));
      pop_acc[c]   = bus.pop[c] && (occ_q[c] != '0);
      // A push into a full FIFO is only legal when a pop drains it the same cycle
      proto_err[c] = (bus.push[c] && !push_acc[c] && !pop_acc[c]) ||
                     (bus.pop[c] && !pop_acc[c]);
      occ_d[c] = occ_q[c];
      if (push_acc[c] && !pop_acc[c]) begin
        occ_d[c] = occ_q[c] + CNTWID'(1);
      end else if (!push_acc[c] && pop_acc[c]) begin
        occ_d[c] = occ_q[c] - CNTWID'(1);
      end
      // Channel muxes built by comparison so an out-of-range sel selects nothing
      if (bus.sel == CHW'(c)) begin
        sel_ok       = 1'b1;
        sel_push_acc = push_acc[c];
        sel_pop_acc  = pop_acc[c];
        sel_occ      = occ_q[c];
        sel_data     = bus.flat_data_in[c*WIDTH +: WIDTH];
      end
      if (ch_q == CHW'(c)) begin
        ch_pop_acc = pop_acc[c];
        ch_data    = bus.flat_data_out[c*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    magic_d  = magic_q;
    ch_d     = ch_q;
    vld      = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && sel_ok && sel_push_acc) begin
          ch_d    = bus.sel;
          magic_d = sel_data;
          pos_d   = sel_occ + CNTWID'(1) - CNTWID'(sel_pop_acc);
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (ch_pop_acc) begin
          pos_d = pos_q - CNTWID'(1);
          if (pos_q == CNTWID'(1)) begin
            vld      = 1'b1;
            mismatch = (ch_data != magic_q);
            state_d  = (REARM == 1) ? IDLE : DONE;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d    = err_q | {(|proto_err), mismatch};
    err_ch_d = err_ch_q;
    found    = 1'b0;
    if ((err_q == '0) && (err_d != '0)) begin
      if (mismatch) begin
        err_ch_d = ch_q;
      end else begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (proto_err[c] && !found) begin
            found    = 1'b1;
            err_ch_d = CHW'(c);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      magic_q  <= '0;
      ch_q     <= '0;
      err_q    <= '0;
      err_ch_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        occ_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      magic_q  <= magic_d;
      ch_q     <= ch_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        occ_q[c] <= occ_d[c];
      end
    end
  end

  assign bus.armed        = (state_q == TRACK);
  assign bus.done         = (state_q == DONE);
  assign bus.data_out_vld = vld;
  assign bus.prop_signal  = ~vld | (magic_q == ch_data);
  assign bus.err          = err_q;
  assign bus.err_ch       = err_ch_q;
endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Bench for multi_channel_scoreboard: per-cycle reference model with tagged FIFO
// queues, table-driven packet scenarios and hand-written corner sequences.
module tb_multi_channel_scoreboard;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_channel_scoreboard_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) if0 ();
  multi_channel_scoreboard_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) if1 ();

  multi_channel_scoreboard #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .REARM(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  multi_channel_scoreboard #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .REARM(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  logic        tgt;
  logic [3:0]  p_push, p_pop;
  logic        p_start;
  logic [1:0]  p_sel;
  logic [31:0] p_din, p_dout;

  assign if0.push          = tgt ? '0 : p_push;
  assign if0.pop           = tgt ? '0 : p_pop;
  assign if0.start         = tgt ? 1'b0 : p_start;
  assign if0.sel           = tgt ? '0 : p_sel;
  assign if0.flat_data_in  = tgt ? '0 : p_din;
  assign if0.flat_data_out = tgt ? '0 : p_dout;
  assign if1.push          = tgt ? p_push : '0;
  assign if1.pop           = tgt ? p_pop : '0;
  assign if1.start         = tgt ? p_start : 1'b0;
  assign if1.sel           = tgt ? p_sel : '0;
  assign if1.flat_data_in  = tgt ? p_din : '0;
  assign if1.flat_data_out = tgt ? p_dout : '0;

  typedef struct {
    logic [3:0] push;
    logic [3:0] pop;
    logic       start;
    logic [1:0] sel;
    logic [7:0] dval;
    logic [3:0] ovr;
    logic [7:0] ovv;
    logic [7:0] xb;   // {armed, done, vld, prop, err[1:0], err_ch[1:0]}
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] magic;
  } sb_t;

  logic [8:0] fq [NUM_CH][$];   // bit 8 tags the captured packet
  int         m_state;          // 0 idle, 1 track, 2 done
  logic [1:0] m_ch, m_err, m_errch;
  logic [7:0] m_magic;
  sb_t        sb_q[$];

  logic [7:0] s_out;
  int         n_checks = 0;
  int         n_err = 0;
  int         step_no = 0;
  int         vld_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fdin(input logic [1:0] sl, input logic [7:0] dv);
    logic [31:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*8 +: 8] = (c == int'(sl)) ? dv : (8'hE0 | 8'(c));
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] pu, input logic [3:0] po, input logic st,
                              input logic [1:0] sl, input logic [7:0] dv, input logic [7:0] xb);
    vec_t v;
    v.push = pu; v.pop = po; v.start = st; v.sel = sl; v.dval = dv;
    v.ovr = 4'b0; v.ovv = 8'h00; v.xb = xb;
    return v;
  endfunction

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic step(input logic r, input logic [3:0] pu, input logic [3:0] po, input logic st,
                      input logic [1:0] sl, input logic [7:0] dv, input logic [3:0] ovr,
                      input logic [7:0] ovv);
    logic [3:0]  pa, ua, perr;
    logic [31:0] din, dout;
    logic        ev, mis, cap, ep, found;
    logic [1:0]  nerr;
    logic [7:0]  exp_b, tdat;
    sb_t         e;
    din = fdin(sl, dv);
    for (int c = 0; c < NUM_CH; c++) begin
      int occ;
      occ = fq[c].size();
      dout[c*8 +: 8] = ovr[c] ? ovv : ((occ > 0) ? fq[c][0][7:0] : 8'h00);
      pa[c]   = po[c] && (occ > 0);
      ua[c]   = pu[c] && (occ < DEPTH);
      perr[c] = (pu[c] && (occ == DEPTH) && !pa[c]) || (po[c] && (occ == 0));
    end
    rst = r; p_push = pu; p_pop = po; p_start = st; p_sel = sl; p_din = din; p_dout = dout;
    ev = 1'b0;
    if ((m_state == 1) && pa[m_ch] && (fq[m_ch].size() > 0)) ev = fq[m_ch][0][8];
    tdat = dout[m_ch*8 +: 8];
    mis  = ev && (tdat != m_magic);
    ep   = !ev || (tdat == m_magic);
    cap  = (m_state == 0) && st && ua[sl];
    #4;
    s_out = tgt ? {if1.armed, if1.done, if1.data_out_vld, if1.prop_signal, if1.err, if1.err_ch}
                : {if0.armed, if0.done, if0.data_out_vld, if0.prop_signal, if0.err, if0.err_ch};
    exp_b = {(m_state == 1), (m_state == 2), ev, ep, m_err, m_errch};
    check($sformatf("model_step%0d", step_no), {24'h0, s_out}, {24'h0, exp_b});
    if (s_out[5]) begin
      vld_pulses++;
      if (sb_q.size() == 0) begin
        check($sformatf("sb_spurious_vld_step%0d", step_no), {31'h0, s_out[5]}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("sb_prop_step%0d", step_no), {31'h0, s_out[4]},
              {31'h0, (dout[e.ch*8 +: 8] == e.magic)});
      end
    end
    if (r) begin
      for (int c = 0; c < NUM_CH; c++) fq[c].delete();
      m_state = 0; m_err = 2'b0; m_errch = 2'b0; m_ch = 2'b0; m_magic = 8'h00;
      sb_q.delete();
    end else begin
      nerr = m_err | {(|perr), mis};
      if ((m_err == 2'b0) && (nerr != 2'b0)) begin
        if (mis) m_errch = m_ch;
        else begin
          found = 1'b0;
          for (int c = 0; c < NUM_CH; c++)
            if (perr[c] && !found) begin found = 1'b1; m_errch = 2'(c); end
        end
      end
      m_err = nerr;
      for (int c = 0; c < NUM_CH; c++) begin
        if (pa[c]) void'(fq[c].pop_front());
        if (ua[c]) fq[c].push_back({(cap && (c == int'(sl))), din[c*8 +: 8]});
      end
      if (cap) begin
        m_state = 1; m_ch = sl; m_magic = din[sl*8 +: 8];
        e.ch = sl; e.magic = din[sl*8 +: 8];
        sb_q.push_back(e);
      end else if (ev) begin
        m_state = tgt ? 0 : 2;
      end
    end
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic idle();
    step(1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 8'h00, 4'b0, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0, 4'b0, 1'b0, 2'd0, 8'h00, 4'b0, 8'h00);
  endtask

  vec_t t34[9];
  vec_t t35[9];
  logic [4:0] armed_seq;
  int         vp0;

  initial begin
    t34[0] = mk(4'b0100, 4'b0000, 1'b0, 2'd2, 8'h05, 8'h10);
    t34[1] = mk(4'b0100, 4'b0000, 1'b0, 2'd2, 8'h06, 8'h10);
    t34[2] = mk(4'b0100, 4'b0000, 1'b0, 2'd2, 8'h07, 8'h10);
    t34[3] = mk(4'b0100, 4'b0000, 1'b1, 2'd2, 8'hAB, 8'h10);
    t34[4] = mk(4'b0000, 4'b0100, 1'b0, 2'd0, 8'h00, 8'h90);
    t34[5] = mk(4'b0000, 4'b0100, 1'b0, 2'd0, 8'h00, 8'h90);
    t34[6] = mk(4'b0000, 4'b0100, 1'b0, 2'd0, 8'h00, 8'h90);
    t34[7] = mk(4'b0000, 4'b0100, 1'b0, 2'd0, 8'h00, 8'hB0);
    t34[8] = mk(4'b0000, 4'b0000, 1'b1, 2'd2, 8'h00, 8'h50);
    t35 = t34;
    t35[7].ovr = 4'b0100; t35[7].ovv = 8'hAC; t35[7].xb = 8'hA0;
    t35[8].xb = 8'h56;

    tgt = 1'b0; rst = 1'b1;
    p_push = '0; p_pop = '0; p_start = 1'b0; p_sel = '0; p_din = '0; p_dout = '0;
    m_state = 0; m_err = 2'b0; m_errch = 2'b0; m_ch = 2'b0; m_magic = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    check("reset_dut0", {24'h0, if0.armed, if0.done, if0.data_out_vld, if0.prop_signal, if0.err, if0.err_ch}, 32'h10);
    check("reset_dut1", {24'h0, if1.armed, if1.done, if1.data_out_vld, if1.prop_signal, if1.err, if1.err_ch}, 32'h10);
    @(posedge clk); #1;

    // Magic packet exits intact, then with corrupted data
    for (int k = 0; k < 9; k++) begin
      step(1'b0, t34[k].push, t34[k].pop, t34[k].start, t34[k].sel, t34[k].dval, t34[k].ovr, t34[k].ovv);
      check($sformatf("tbl_good_row%0d", k), {24'h0, s_out}, {24'h0, t34[k].xb});
    end
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(1'b0, t35[k].push, t35[k].pop, t35[k].start, t35[k].sel, t35[k].dval, t35[k].ovr, t35[k].ovv);
      check($sformatf("tbl_bad_row%0d", k), {24'h0, s_out}, {24'h0, t35[k].xb});
    end

    // Capture on empty ch0 with simultaneous (ignored, flagged) pop
    do_reset();
    step(1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h3C, 4'b0, 8'h00);
    step(1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 8'h00, 4'b0, 8'h00);
    check("empty_capture_exit", {24'h0, s_out}, 32'hB8);
    idle();
    check("empty_capture_done", {24'h0, s_out}, 32'h58);

    // Simultaneous underflow on ch1 and ch3 records lowest channel
    do_reset();
    step(1'b0, 4'b0000, 4'b1010, 1'b0, 2'd0, 8'h00, 4'b0, 8'h00);
    idle();
    check("underflow_lowest_ch", {24'h0, s_out}, 32'h19);

    // Overflow ch1, then prove occupancy stayed at DEPTH via capture position
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'b0010, 4'b0, 1'b0, 2'd1, 8'(8'h40 + i), 4'b0, 8'h00);
    step(1'b0, 4'b0010, 4'b0, 1'b0, 2'd1, 8'h4F, 4'b0, 8'h00);
    idle();
    check("overflow_flag", {24'h0, s_out}, 32'h19);
    step(1'b0, 4'b0000, 4'b0010, 1'b0, 2'd1, 8'h00, 4'b0, 8'h00);
    step(1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h5A, 4'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'b0000, 4'b0010, 1'b0, 2'd1, 8'h00, 4'b0, 8'h00);
    check("overflow_exit_pos", {24'h0, s_out}, 32'hB9);

    // Reset mid-TRACK with pos=3 and a same-cycle pop
    do_reset();
    step(1'b0, 4'b0010, 4'b0, 1'b0, 2'd1, 8'h21, 4'b0, 8'h00);
    step(1'b0, 4'b0010, 4'b0, 1'b0, 2'd1, 8'h22, 4'b0, 8'h00);
    step(1'b0, 4'b0010, 4'b0, 1'b1, 2'd1, 8'h23, 4'b0, 8'h00);
    step(1'b1, 4'b0000, 4'b0010, 1'b0, 2'd1, 8'h00, 4'b0, 8'h00);
    idle();
    check("reset_in_track", {24'h0, s_out}, 32'h10);
    idle();

    // REARM=1 instance: back-to-back captures on ch0 then ch3
    tgt = 1'b1;
    do_reset();
    vp0 = vld_pulses;
    step(1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h11, 4'b0, 8'h00); armed_seq[4] = s_out[7];
    step(1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 8'h00, 4'b0, 8'h00); armed_seq[3] = s_out[7];
    step(1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 8'h33, 4'b0, 8'h00); armed_seq[2] = s_out[7];
    step(1'b0, 4'b0000, 4'b1000, 1'b0, 2'd0, 8'h00, 4'b0, 8'h00); armed_seq[1] = s_out[7];
    idle();                                                        armed_seq[0] = s_out[7];
    check("rearm_armed_seq", {27'h0, armed_seq}, 32'b01010);
    check("rearm_vld_pulses", vld_pulses - vp0, 32'd2);
    check("rearm_not_done", {31'h0, s_out[6]}, 32'h0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
